boss_phase_scheduler: RTL
=========================

# boss_phase_scheduler

Sequencer for the boss attack engine. Turns a per-frame pulse into the `pulse_cycleStep` pulses that advance the boss attack pattern. Chooses the beam wind-up `delay` from a difficulty phase derived from boss HP. Owns the game-level IDLE / lead-in / run / won flow and issues a one-cycle `boss_rst` so the boss controller restarts cleanly for each round.

## Interface
Parameters:
- `BOSS_HP`, 540: full boss HP, used for the phase thresholds.
- `PHASE2_HP`, 360: HP at or below this selects phase 1.
- `PHASE3_HP`, 180: HP at or below this selects phase 2.
- `LEADIN_FRAMES`, 120: frames between round start and the RUN state. Range 1..255.
- `STEP_FRAMES_P0`, 90: frames per attack step in phase 0. Range 1..255.
- `STEP_FRAMES_P1`, 60: frames per attack step in phase 1. Range 1..255.
- `STEP_FRAMES_P2`, 40: frames per attack step in phase 2. Range 1..255.
- `DELAY_P0`, 50_000_000: beam wind-up delay in phase 0, in clk_master cycles.
- `DELAY_P1`, 35_000_000: beam wind-up delay in phase 1, in clk_master cycles.
- `DELAY_P2`, 25_000_000: beam wind-up delay in phase 2, in clk_master cycles.

Ports:
- `clk_master` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `pulse_frame` in 1: one-cycle pulse, once per video frame.
- `game_start` in 1: level signal; sampled only in IDLE and WON.
- `pause` in 1: level signal; freezes frame counting while high.
- `bossHP` in 10: current boss HP from the boss controller.
- `pulse_cycleStep` out 1: one-cycle attack-advance pulse to the boss controller.
- `delay` out 32: beam wind-up delay to the boss controller.
- `boss_rst` out 1: one-cycle synchronous reset to the boss controller.
- `phase` out 2: current difficulty phase, 0..2.
- `running` out 1: high while in RUN.
- `game_won` out 1: high while in WON.
- `step_count` out 8: attack steps issued this round; wraps at 255.

## Operation
- Reset values, applied asynchronously on `rst`:
  - state = IDLE; frame_cnt = 0.
  - `pulse_cycleStep` = 0, `boss_rst` = 0.
  - `phase` = 0, `delay` = DELAY_P0.
  - `running` = 0, `game_won` = 0, `step_count` = 0.
- States: IDLE, LEADIN, RUN, WON.
- IDLE:
  - Outputs quiet.
  - `game_start` = 1 → LEADIN. On the same edge: `boss_rst` pulses, frame_cnt = 0, step_count = 0, phase = 0, delay = DELAY_P0.
- LEADIN:
  - On a `pulse_frame` with `pause` = 0: if frame_cnt == LEADIN_FRAMES-1, go to RUN with frame_cnt = 0; otherwise frame_cnt++.
  - HP is not checked in LEADIN, because the boss controller restores HP one cycle after `boss_rst`.
- RUN:
  - `bossHP` == 0 → WON, regardless of any other input that cycle.
  - Otherwise, on a `pulse_frame` with `pause` = 0: if frame_cnt == step_frames(phase)-1, pulse `pulse_cycleStep`, set frame_cnt = 0 and step_count++. Otherwise frame_cnt++.
- WON:
  - `game_won` = 1, no step pulses.
  - `game_start` = 1 → LEADIN, with the same side effects as leaving IDLE.
- `game_start` is ignored in LEADIN and RUN.
- Phase tracking (RUN only):
  - target = 0 if bossHP > PHASE2_HP; 1 if bossHP > PHASE3_HP; otherwise 2.
  - phase <= max(phase, target). Phase is monotonic within a round and clears only via `rst` or round start.
  - `delay` is registered from the same next-phase value, so `phase` and `delay` always change on the same edge.
- A phase change mid-step does not clear frame_cnt.
  - If frame_cnt ≥ new step_frames-1, the next unpaused `pulse_frame` fires a step.
  - The compare is ≥, not ==, so no step is lost.
- `pause` has no effect in IDLE or WON. `pulse_frame` is ignored in those states.

## Timing
- All outputs are registered.
- `pulse_cycleStep` rises on the clock edge that samples the qualifying `pulse_frame` and lasts exactly one cycle.
- `boss_rst` is high for exactly the first cycle after game_start is accepted.
- `running` is high from the edge entering RUN to the edge leaving it.
- WON is entered on the edge that samples bossHP == 0; `running` drops and `game_won` rises on that same edge.
- Step spacing in steady state is step_frames(phase) frames, plus any paused frames.
- Asynchronous `rst` mid-round aborts immediately to IDLE and asserts no `boss_rst`; the boss controller takes the global `rst` directly.
- Simultaneous events:
  - Step due and bossHP == 0 in the same cycle: WON, no pulse.
  - Step due and `pause` = 1: no pulse, frame_cnt held.

## Test plan
Test parameter set: LEADIN_FRAMES=2, STEP_FRAMES_P0=3, STEP_FRAMES_P1=2, STEP_FRAMES_P2=1; `pulse_frame` every 10 cycles.
- Reset then start: assert and release `rst`, then `game_start` for 1 cycle → `boss_rst` is one cycle wide; `running` rises after the 2nd frame; the first `pulse_cycleStep` comes on the 3rd frame after RUN entry, then every 3rd frame; step_count counts 1, 2, 3.
- Phase: bossHP=540 → 360 → 361 → 100 during RUN → phase goes 0, 1, stays 1, then 2; delay goes 50_000_000, 35_000_000, 35_000_000, 25_000_000; step spacing becomes 2 frames, then 1 frame.
- Pause: hold `pause` for 5 frames mid-step → no pulses and frame_cnt frozen; the step fires at its remaining count after release.
- Win collision: drive bossHP=0 on the same cycle a step is due → no `pulse_cycleStep`; `game_won`=1 and `running`=0 on the next edge.
- Restart from WON: `game_start` → `boss_rst` pulse, step_count=0, phase=0, delay=50_000_000; bossHP still 0 during LEADIN does not re-enter WON.
- Async reset in RUN: assert `rst` between clock edges → all outputs reach their reset values before the next edge.

Source files
------------

// File: rtl/boss_phase_scheduler_if.sv
// Signal bundle between the boss phase scheduler and the boss attack engine.
// The scheduler sits on the slave modport; the game/engine side uses master.
interface boss_phase_scheduler_if;
    logic        pulse_frame;
    logic        game_start;
    logic        pause;
    logic [9:0]  bossHP;
    logic        pulse_cycleStep;
    logic [31:0] delay;
    logic        boss_rst;
    logic [1:0]  phase;
    logic        running;
    logic        game_won;
    logic [7:0]  step_count;

    modport master (
        output pulse_frame, game_start, pause, bossHP,
        input  pulse_cycleStep, delay, boss_rst, phase, running, game_won, step_count
    );

    modport slave (
        input  pulse_frame, game_start, pause, bossHP,
        output pulse_cycleStep, delay, boss_rst, phase, running, game_won, step_count
    );
endinterface

// File: rtl/boss_phase_scheduler.sv
// Round flow (IDLE / LEADIN / RUN / WON) and frame-to-step pacing for the boss
// attack engine; picks step rate and beam wind-up delay from an HP-derived phase.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | power-up, waiting for game_start
// S_LEADIN | round started, counting lead-in frames before the attack
// S_RUN    | attack running, issuing step pulses, tracking phase
// S_WON    | boss HP reached 0, waiting for game_start to replay
module boss_phase_scheduler #(
    parameter int          BOSS_HP        = 540,
    parameter int          PHASE2_HP      = 360,
    parameter int          PHASE3_HP      = 180,
    parameter int          LEADIN_FRAMES  = 120,
    parameter int          STEP_FRAMES_P0 = 90,
    parameter int          STEP_FRAMES_P1 = 60,
    parameter int          STEP_FRAMES_P2 = 40,
    parameter int unsigned DELAY_P0       = 50_000_000,
    parameter int unsigned DELAY_P1       = 35_000_000,
    parameter int unsigned DELAY_P2       = 25_000_000
) (
    input  logic                     clk_master,
    input  logic                     rst,
    boss_phase_scheduler_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LEADIN = 2'd1,
        S_RUN    = 2'd2,
        S_WON    = 2'd3
    } state_t;

    localparam logic [9:0]  HP_FULL     = 10'(BOSS_HP);
    localparam logic [9:0]  HP_PH2      = 10'(PHASE2_HP);
    localparam logic [9:0]  HP_PH3      = 10'(PHASE3_HP);
    localparam logic [7:0]  LEADIN_LAST = 8'(LEADIN_FRAMES - 1);
    localparam logic [7:0]  STEP_LAST0  = 8'(STEP_FRAMES_P0 - 1);
    localparam logic [7:0]  STEP_LAST1  = 8'(STEP_FRAMES_P1 - 1);
    localparam logic [7:0]  STEP_LAST2  = 8'(STEP_FRAMES_P2 - 1);
    localparam logic [31:0] DLY0        = 32'(DELAY_P0);
    localparam logic [31:0] DLY1        = 32'(DELAY_P1);
    localparam logic [31:0] DLY2        = 32'(DELAY_P2);

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_frame_cnt, w_frame_cnt_nxt;
    logic        r_pulse, w_pulse_nxt;
    logic        r_boss_rst, w_boss_rst_nxt;
    logic [1:0]  r_phase, w_phase_nxt;
    logic [31:0] r_delay, w_delay_nxt;
    logic [7:0]  r_step_count, w_step_count_nxt;
    logic        r_running, r_game_won;

    logic [9:0]  w_hp;
    logic [1:0]  w_target;
    logic [1:0]  w_phase_run;
    logic [7:0]  w_step_last;
    logic        w_frame_ok;

    function automatic logic [31:0] delay_of(input logic [1:0] p);
        case (p)
            2'd0:    return DLY0;
            2'd1:    return DLY1;
            default: return DLY2;
        endcase
    endfunction

    // HP readings above full scale are treated as full HP.
    assign w_hp       = (bus.bossHP > HP_FULL) ? HP_FULL : bus.bossHP;
    assign w_frame_ok = bus.pulse_frame & ~bus.pause;

    always_comb begin
        w_target = 2'd2;
        if (w_hp > HP_PH2) begin
            w_target = 2'd0;
        end else if (w_hp > HP_PH3) begin
            w_target = 2'd1;
        end
    end

    assign w_phase_run = (w_target > r_phase) ? w_target : r_phase;

    // Step length follows the phase in force before this edge; >= keeps a
    // partially elapsed step from being lost when the phase shortens it.
    always_comb begin
        case (r_phase)
            2'd0:    w_step_last = STEP_LAST0;
            2'd1:    w_step_last = STEP_LAST1;
            default: w_step_last = STEP_LAST2;
        endcase
    end

    always_ff @(posedge clk_master or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_frame_cnt  <= 8'd0;
            r_pulse      <= 1'b0;
            r_boss_rst   <= 1'b0;
            r_phase      <= 2'd0;
            r_delay      <= DLY0;
            r_step_count <= 8'd0;
            r_running    <= 1'b0;
            r_game_won   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
            r_pulse      <= w_pulse_nxt;
            r_boss_rst   <= w_boss_rst_nxt;
            r_phase      <= w_phase_nxt;
            r_delay      <= w_delay_nxt;
            r_step_count <= w_step_count_nxt;
            r_running    <= (w_state_nxt == S_RUN);
            r_game_won   <= (w_state_nxt == S_WON);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_frame_cnt_nxt  = r_frame_cnt;
        w_pulse_nxt      = 1'b0;
        w_boss_rst_nxt   = 1'b0;
        w_phase_nxt      = r_phase;
        w_delay_nxt      = r_delay;
        w_step_count_nxt = r_step_count;

        case (r_state)
            S_IDLE, S_WON: begin
                if (bus.game_start) begin
                    w_state_nxt      = S_LEADIN;
                    w_boss_rst_nxt   = 1'b1;
                    w_frame_cnt_nxt  = 8'd0;
                    w_step_count_nxt = 8'd0;
                    w_phase_nxt      = 2'd0;
                    w_delay_nxt      = DLY0;
                end
            end
            // HP is ignored here: the engine restores it only after boss_rst.
            S_LEADIN: begin
                if (w_frame_ok) begin
                    if (r_frame_cnt >= LEADIN_LAST) begin
                        w_state_nxt     = S_RUN;
                        w_frame_cnt_nxt = 8'd0;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + 8'd1;
                    end
                end
            end
            S_RUN: begin
                w_phase_nxt = w_phase_run;
                w_delay_nxt = delay_of(w_phase_run);
                if (bus.bossHP == 10'd0) begin
                    w_state_nxt = S_WON;
                end else if (w_frame_ok) begin
                    if (r_frame_cnt >= w_step_last) begin
                        w_pulse_nxt      = 1'b1;
                        w_frame_cnt_nxt  = 8'd0;
                        w_step_count_nxt = r_step_count + 8'd1;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + 8'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.pulse_cycleStep = r_pulse;
    assign bus.boss_rst        = r_boss_rst;
    assign bus.phase           = r_phase;
    assign bus.delay           = r_delay;
    assign bus.running         = r_running;
    assign bus.game_won        = r_game_won;
    assign bus.step_count      = r_step_count;

endmodule
